opr_micro_encoder: RTL and testbench



---
 rtl/memory_utils_pkg.sv | 38 +++
 rtl/opr_micro_encoder_lut.sv | 43 ++++
 rtl/opr_micro_encoder.sv | 136 +++++++++++++
 tb/tb_opr_micro_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_utils_pkg.sv
// Shared types and constants for the PDP-8 operate-instruction encoder and its mnemonic table.
package memory_utils_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic [4:0] {
    OprNop, OprCla, OprCll, OprCma, OprCml, OprRar, OprRal, OprRtr, OprRtl, OprBsw,
    OprIac, OprSma, OprSza, OprSnl, OprSpa, OprSna, OprSzl, OprSkp, OprOsr, OprHlt
  } opr_mnem_t;

  typedef enum logic [1:0] {GrpNone, GrpG1, GrpG2Or, GrpG2And} opr_group_t;

  // ClsG2Any marks OSR/HLT: valid in either Group 2 flavour, defaulting to G2OR.
  typedef enum logic [2:0] {ClsNeutral, ClsG1, ClsG2Or, ClsG2And, ClsG2Any} opr_class_t;

  localparam word_t OPR_BASE  = 12'o7000;
  localparam word_t OPR_CLA   = 12'o0200;
  localparam word_t OPR_CLL   = 12'o0100;
  localparam word_t OPR_CMA   = 12'o0040;
  localparam word_t OPR_CML   = 12'o0020;
  localparam word_t OPR_RAR   = 12'o0010;
  localparam word_t OPR_RAL   = 12'o0004;
  localparam word_t OPR_RTR   = 12'o0012;
  localparam word_t OPR_RTL   = 12'o0006;
  localparam word_t OPR_BSW   = 12'o0002;
  localparam word_t OPR_IAC   = 12'o0001;
  localparam word_t OPR_G2OR  = 12'o0400;
  localparam word_t OPR_G2AND = 12'o0410;
  localparam word_t OPR_SMA   = 12'o0100;
  localparam word_t OPR_SZA   = 12'o0040;
  localparam word_t OPR_SNL   = 12'o0020;
  localparam word_t OPR_SPA   = 12'o0100;
  localparam word_t OPR_SNA   = 12'o0040;
  localparam word_t OPR_SZL   = 12'o0020;
  localparam word_t OPR_OSR   = 12'o0004;
  localparam word_t OPR_HLT   = 12'o0002;

endpackage

// File: rtl/opr_micro_encoder_lut.sv
// Combinational mnemonic table: bit mask (group bits included), group class, rotate flag, legality.
module opr_mnem_lut
  import memory_utils_pkg::*;
(
  input  logic [4:0]  code_i,
  output word_t       mask_o,
  output opr_class_t  cls_o,
  output logic        is_rotate_o,
  output logic        legal_o
);

  always_comb begin
    mask_o      = '0;
    cls_o       = ClsNeutral;
    is_rotate_o = 1'b0;
    legal_o     = 1'b1;
    case (code_i)
      OprNop: ;
      OprCla: mask_o = OPR_CLA;
      OprCll: begin mask_o = OPR_CLL; cls_o = ClsG1; end
      OprCma: begin mask_o = OPR_CMA; cls_o = ClsG1; end
      OprCml: begin mask_o = OPR_CML; cls_o = ClsG1; end
      OprRar: begin mask_o = OPR_RAR; cls_o = ClsG1; is_rotate_o = 1'b1; end
      OprRal: begin mask_o = OPR_RAL; cls_o = ClsG1; is_rotate_o = 1'b1; end
      OprRtr: begin mask_o = OPR_RTR; cls_o = ClsG1; is_rotate_o = 1'b1; end
      OprRtl: begin mask_o = OPR_RTL; cls_o = ClsG1; is_rotate_o = 1'b1; end
      OprBsw: begin mask_o = OPR_BSW; cls_o = ClsG1; is_rotate_o = 1'b1; end
      OprIac: begin mask_o = OPR_IAC; cls_o = ClsG1; end
      OprSma: begin mask_o = OPR_G2OR | OPR_SMA; cls_o = ClsG2Or; end
      OprSza: begin mask_o = OPR_G2OR | OPR_SZA; cls_o = ClsG2Or; end
      OprSnl: begin mask_o = OPR_G2OR | OPR_SNL; cls_o = ClsG2Or; end
      OprSpa: begin mask_o = OPR_G2AND | OPR_SPA; cls_o = ClsG2And; end
      OprSna: begin mask_o = OPR_G2AND | OPR_SNA; cls_o = ClsG2And; end
      OprSzl: begin mask_o = OPR_G2AND | OPR_SZL; cls_o = ClsG2And; end
      OprSkp: begin mask_o = OPR_G2AND; cls_o = ClsG2And; end
      // 0400 is OR-safe under G2AND too, so OSR/HLT can always carry it.
      OprOsr: begin mask_o = OPR_G2OR | OPR_OSR; cls_o = ClsG2Any; end
      OprHlt: begin mask_o = OPR_G2OR | OPR_HLT; cls_o = ClsG2Any; end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/opr_micro_encoder.sv
// Assembles a stream of OPR micro-op mnemonics into one PDP-8 operate word, or flags an error.
module opr_micro_encoder
  import memory_utils_pkg::*;
#(
  parameter int unsigned MAX_OPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [4:0]  op_code,
  input  logic        op_last,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [11:0] instr,
  output logic        instr_error
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StEmit} state_t;

  state_t     state_q, state_d;
  word_t      acc_q, acc_d;
  word_t      instr_q, instr_d;
  opr_group_t grp_q, grp_d, grp_new;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       instr_error_q, instr_error_d;

  word_t      lut_mask;
  opr_class_t lut_cls;
  logic       lut_rot, lut_legal;
  logic       grp_conflict, rot_conflict, cnt_over, op_err;

  opr_mnem_lut u_lut (
    .code_i      (op_code),
    .mask_o      (lut_mask),
    .cls_o       (lut_cls),
    .is_rotate_o (lut_rot),
    .legal_o     (lut_legal)
  );

  always_comb begin
    grp_new      = grp_q;
    grp_conflict = 1'b0;
    case (lut_cls)
      ClsG1: begin
        grp_new      = GrpG1;
        grp_conflict = (grp_q == GrpG2Or) || (grp_q == GrpG2And);
      end
      ClsG2Or: begin
        grp_new      = GrpG2Or;
        grp_conflict = (grp_q == GrpG1) || (grp_q == GrpG2And);
      end
      ClsG2And: begin
        grp_new      = GrpG2And;
        grp_conflict = (grp_q == GrpG1) || (grp_q == GrpG2Or);
      end
      ClsG2Any: begin
        grp_new      = (grp_q == GrpNone) ? GrpG2Or : grp_q;
        grp_conflict = (grp_q == GrpG1);
      end
      default: ;
    endcase
  end

  // Bits 3:1 of a Group 1 word hold only the rotate field; a different non-zero value conflicts.
  assign rot_conflict = lut_rot && (acc_q[3:1] != 3'b000) && (acc_q[3:1] != lut_mask[3:1]);
  assign cnt_over     = ({28'd0, cnt_q} >= MAX_OPS);
  assign op_err       = !lut_legal || cnt_over || grp_conflict || rot_conflict;
  assign cnt_inc      = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    grp_d         = grp_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    instr_error_d = instr_error_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (op_valid) begin
          cnt_d = cnt_inc;
          if (!op_err) begin
            acc_d = acc_q | lut_mask;
            grp_d = grp_new;
          end
          if (op_last) begin
            state_d       = StEmit;
            instr_d       = op_err ? OPR_BASE : (OPR_BASE | acc_q | lut_mask);
            instr_error_d = op_err;
          end else begin
            state_d = op_err ? StDrain : StAccum;
          end
        end
      end
      StDrain: begin
        if (op_valid && op_last) begin
          state_d       = StEmit;
          instr_d       = OPR_BASE;
          instr_error_d = 1'b1;
        end
      end
      StEmit: begin
        if (instr_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          grp_d   = GrpNone;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      grp_q         <= GrpNone;
      cnt_q         <= '0;
      instr_q       <= OPR_BASE;
      instr_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      grp_q         <= grp_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      instr_error_q <= instr_error_d;
    end
  end

  assign op_ready    = (state_q != StEmit);
  assign instr_valid = (state_q == StEmit);
  assign instr       = instr_q;
  assign instr_error = instr_error_q;

endmodule

// File: tb/tb_opr_micro_encoder.sv
// Self-checking bench: directed cases plus random mnemonic streams against a behavioural model.
module tb_opr_micro_encoder;
  import memory_utils_pkg::*;

  localparam int unsigned MaxOps = 8;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_ready, op_last;
  logic        instr_valid, instr_ready, instr_error;
  logic [4:0]  op_code;
  logic [11:0] instr;

  int checks = 0;
  int failures = 0;

  // Octal contribution, group kind (0 neutral, 1 G1, 2 G2OR, 3 G2AND, 4 either G2) per mnemonic.
  localparam logic [11:0] Val [20] = '{
    12'o0, 12'o200, 12'o100, 12'o40, 12'o20, 12'o10, 12'o4, 12'o12, 12'o6, 12'o2,
    12'o1, 12'o100, 12'o40, 12'o20, 12'o100, 12'o40, 12'o20, 12'o0, 12'o4, 12'o2};
  localparam int Kind [20] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4};

  always #5 clk = ~clk;

  opr_micro_encoder #(.MAX_OPS(MaxOps)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_last     (op_last),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_error (instr_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  function automatic void model(input int ops[$], output logic [11:0] w, output logic e);
    int grp = 0;
    int rot = -1;
    logic [11:0] acc = '0;
    e = 1'b0;
    foreach (ops[i]) begin
      int c = ops[i];
      if (i >= int'(MaxOps) || c >= 20) begin
        e = 1'b1;
        continue;
      end
      if (Kind[c] == 4) begin
        if (grp == 1) e = 1'b1;
        else if (grp == 0) grp = 2;
      end else if (Kind[c] != 0) begin
        if (grp != 0 && grp != Kind[c]) e = 1'b1;
        else grp = Kind[c];
      end
      if (c >= 5 && c <= 9) begin
        if (rot >= 0 && rot != c) e = 1'b1;
        else rot = c;
      end
      acc |= Val[c];
    end
    if (grp == 2) acc |= 12'o400;
    else if (grp == 3) acc |= 12'o410;
    w = e ? 12'o7000 : (12'o7000 | acc);
  endfunction

  task automatic send_op(input int code, input bit last);
    int waited = 0;
    op_code  = 5'(code);
    op_last  = last;
    op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      check("op_ready_timeout", 32'(op_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic send_ops(input int ops[$], input bit gaps);
    foreach (ops[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      send_op(ops[i], i == ops.size() - 1);
    end
  endtask

  // Entered one step after the op_last edge; the word must already be valid.
  task automatic take_word(input logic [11:0] ew, input logic ee, input int hold, input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(instr), 32'(ew));
    check({tag, "_err"}, 32'(instr_error), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_instr"}, 32'(instr), 32'(ew));
      check({tag, "_hold_err"}, 32'(instr_error), 32'(ee));
      check({tag, "_hold_opready"}, 32'(op_ready), 32'd0);
      check({tag, "_hold_valid"}, 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    check({tag, "_released"}, 32'(instr_valid), 32'd0);
    check({tag, "_opready_back"}, 32'(op_ready), 32'd1);
  endtask

  task automatic directed(input int ops[$], input logic [11:0] ew, input logic ee,
                          input int hold, input string tag);
    send_ops(ops, 1'b0);
    take_word(ew, ee, hold, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[$];
    logic [11:0] mw;
    logic me;
    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_last = 1'b0; instr_ready = 1'b0;
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'o7000);
    check("rst_err", 32'(instr_error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    ops = '{OprCla, OprCll};         directed(ops, 12'o7300, 1'b0, 0, "cla_cll");
    ops = '{OprRtl, OprIac};         directed(ops, 12'o7007, 1'b0, 0, "rtl_iac");
    ops = '{OprSpa, OprSna};         directed(ops, 12'o7550, 1'b0, 3, "spa_sna_hold");
    ops = '{OprCla, OprSza};         directed(ops, 12'o7640, 1'b0, 0, "cla_sza");
    ops = '{OprSkp};                 directed(ops, 12'o7410, 1'b0, 0, "skp");
    ops = '{OprSma, OprSpa, OprCll}; directed(ops, 12'o7000, 1'b1, 0, "grp_conflict");
    ops = '{OprCma};                 directed(ops, 12'o7040, 1'b0, 0, "cma_after_err");
    ops = '{OprRar, OprRal};         directed(ops, 12'o7000, 1'b1, 0, "two_rotates");
    ops = '{OprRar, OprRar};         directed(ops, 12'o7010, 1'b0, 0, "rar_repeat");
    ops = '{OprSpa, OprOsr};         directed(ops, 12'o7514, 1'b0, 0, "spa_osr");
    ops = '{OprOsr, OprSpa};         directed(ops, 12'o7000, 1'b1, 0, "osr_then_spa");
    ops = '{OprHlt};                 directed(ops, 12'o7402, 1'b0, 0, "hlt_alone");
    ops = '{OprCll, OprHlt};         directed(ops, 12'o7000, 1'b1, 1, "g1_hlt");
    ops = '{25};                     directed(ops, 12'o7000, 1'b1, 0, "undefined");
    ops = {};
    for (int i = 0; i < 8; i++) ops.push_back(OprNop);
    directed(ops, 12'o7000, 1'b0, 0, "eight_nops");
    ops.push_back(OprNop);
    directed(ops, 12'o7000, 1'b1, 0, "nine_nops");

    send_op(OprCma, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_op_ready", 32'(op_ready), 32'd1);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", 32'(instr), 32'o7000);
    check("midrst_err", 32'(instr_error), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    ops = '{OprIac};                 directed(ops, 12'o7001, 1'b0, 0, "iac_after_rst");

    for (int n = 0; n < 60; n++) begin
      int fam = $urandom_range(0, 2);
      int len = $urandom_range(1, 9);
      ops = {};
      for (int k = 0; k < len; k++) begin
        int pick = $urandom_range(0, 9);
        int c;
        if (pick == 0) c = $urandom_range(0, 23);
        else if (pick < 3) c = $urandom_range(0, 1);
        else if (fam == 0) c = $urandom_range(2, 10);
        else if (fam == 1) c = (pick < 6) ? $urandom_range(11, 13) : $urandom_range(18, 19);
        else c = $urandom_range(14, 19);
        ops.push_back(c);
      end
      model(ops, mw, me);
      send_ops(ops, 1'b1);
      take_word(mw, me, $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
